// File: rtl/flash_access_arbiter_pkg.sv
// Shared definitions for the flash access arbiter: parameter defaults,
// FSM state encoding and small state-classification helpers.
package flash_access_arbiter_pkg;

  // Default geometry of the flash_manager port
  localparam int ADDR_W_DEF  = 23;
  localparam int DATA_W_DEF  = 16;

  // Watchdog defaults; 2**TO_W must exceed TIMEOUT
  localparam int TIMEOUT_DEF = 1024;
  localparam int TO_W_DEF    = 11;

  // Arbiter states, 4-bit encoding shared with flash_manager users
  typedef enum logic [3:0] {
    BOOT     = 4'd0,
    RD_IDLE  = 4'd1,
    RD_ISSUE = 4'd2,
    RD_WAIT  = 4'd3,
    RD_DONE  = 4'd4,
    WR_RESET = 4'd5,
    WR_ERASE = 4'd6,
    WR_IDLE  = 4'd7,
    WR_ISSUE = 4'd8,
    WR_WAIT  = 4'd9,
    WR_EXIT  = 4'd10
  } arb_state_e;

  // States whose duration is bounded by the watchdog
  function automatic logic is_timed(input arb_state_e s);
    return (s == RD_ISSUE) || (s == RD_WAIT) ||
           (s == WR_ISSUE) || (s == WR_WAIT);
  endfunction

  // States in which flash_manager must be held in writemode
  function automatic logic in_write_mode(input arb_state_e s);
    return (s == WR_RESET) || (s == WR_ERASE) || (s == WR_IDLE) ||
           (s == WR_ISSUE) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/flash_access_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the client that was not served last
// wins, otherwise whichever single client is requesting is granted.
module flash_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic gnt_valid
);

  // Combinational pick; grant is only meaningful while gnt_valid is high
  always_comb begin
    gnt_valid = req0 | req1;
    grant     = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/flash_access_arbiter.sv
// Shares the single flash_manager port between two read clients and one
// write client. Reads are arbitrated round-robin; a write session puts the
// manager in writemode (via a manager reset and erase), streams sequential
// writes, then returns to read mode. Every read/write transaction is bounded
// by a watchdog; expiry sets a sticky error and completes the transaction.
module flash_access_arbiter
  import flash_access_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  // read clients
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_data,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_data,
  // write client
  input  logic              wsess,
  output logic              wr_ready,
  input  logic              w_req,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ack,
  output logic              err,
  // flash_manager side
  output logic              mgr_reset,
  output logic              mgr_writemode,
  output logic              mgr_dowrite,
  output logic [DATA_W-1:0] mgr_wdata,
  output logic              mgr_doread,
  output logic [ADDR_W-1:0] mgr_raddr,
  input  logic              mgr_busy,
  input  logic [DATA_W-1:0] mgr_rdata
);

  arb_state_e        state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic              cur_client, cur_client_nxt;
  logic [TO_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              seen_busy, seen_busy_nxt;
  logic              timeout;

  logic              c0_ack_nxt, c1_ack_nxt, w_ack_nxt, err_nxt;
  logic [DATA_W-1:0] c0_data_nxt, c1_data_nxt, mgr_wdata_nxt;
  logic [ADDR_W-1:0] mgr_raddr_nxt;
  logic              wr_ready_nxt, mgr_reset_nxt, mgr_writemode_nxt;
  logic              mgr_dowrite_nxt, mgr_doread_nxt;

  logic              pick_req0, pick_req1, pick_grant, pick_valid;

  // A client's req is still high during its ack cycle; ignore it there so the
  // same read is not granted twice.
  assign pick_req0 = c0_req & ~c0_ack;
  assign pick_req1 = c1_req & ~c1_ack;

  flash_rr_pick2 u_pick (
    .req0       (pick_req0),
    .req1       (pick_req1),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .gnt_valid  (pick_valid)
  );

  assign timeout = is_timed(state) && (wd_cnt == TO_W'(TIMEOUT - 1));

  // Next-state, bookkeeping and next registered output values
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_client_nxt = cur_client;
    wd_cnt_nxt     = (&wd_cnt) ? wd_cnt : wd_cnt + TO_W'(1);
    seen_busy_nxt  = seen_busy | mgr_busy;
    c0_ack_nxt     = 1'b0;
    c1_ack_nxt     = 1'b0;
    w_ack_nxt      = 1'b0;
    err_nxt        = err;
    c0_data_nxt    = c0_data;
    c1_data_nxt    = c1_data;
    mgr_wdata_nxt  = mgr_wdata;
    mgr_raddr_nxt  = mgr_raddr;

    unique case (state)
      BOOT: begin
        if (!mgr_busy) state_nxt = RD_IDLE;
      end

      RD_IDLE: begin
        if (wsess) begin
          state_nxt = WR_RESET;
        end else if (pick_valid) begin
          cur_client_nxt = pick_grant;
          mgr_raddr_nxt  = pick_grant ? c1_addr : c0_addr;
          wd_cnt_nxt     = '0;
          state_nxt      = RD_ISSUE;
        end
      end

      RD_ISSUE, RD_WAIT: begin
        if (timeout) begin
          err_nxt        = 1'b1;
          last_grant_nxt = cur_client;
          if (cur_client) begin
            c1_ack_nxt  = 1'b1;
            c1_data_nxt = '1;
          end else begin
            c0_ack_nxt  = 1'b1;
            c0_data_nxt = '1;
          end
          state_nxt = RD_IDLE;
        end else if (state == RD_ISSUE && mgr_busy) begin
          state_nxt = RD_WAIT;
        end else if (state == RD_WAIT && !mgr_busy) begin
          state_nxt = RD_DONE;
        end
      end

      RD_DONE: begin
        last_grant_nxt = cur_client;
        if (cur_client) begin
          c1_ack_nxt  = 1'b1;
          c1_data_nxt = mgr_rdata;
        end else begin
          c0_ack_nxt  = 1'b1;
          c0_data_nxt = mgr_rdata;
        end
        state_nxt = RD_IDLE;
      end

      WR_RESET: begin
        state_nxt = WR_ERASE;
      end

      WR_ERASE: begin
        if (seen_busy && !mgr_busy) state_nxt = WR_IDLE;
      end

      WR_IDLE: begin
        if (w_req) begin
          mgr_wdata_nxt = w_data;
          wd_cnt_nxt    = '0;
          state_nxt     = WR_ISSUE;
        end else if (!wsess) begin
          wd_cnt_nxt = '0;
          state_nxt  = WR_EXIT;
        end
      end

      WR_ISSUE, WR_WAIT: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          w_ack_nxt = 1'b1;
          state_nxt = WR_IDLE;
        end else if (state == WR_ISSUE) begin
          state_nxt = WR_WAIT;
        end else if (seen_busy && !mgr_busy) begin
          w_ack_nxt = 1'b1;
          state_nxt = WR_IDLE;
        end
      end

      WR_EXIT: begin
        if (wd_cnt != '0 && !mgr_busy) state_nxt = RD_IDLE;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase

    if (state_nxt != state) seen_busy_nxt = 1'b0;

    mgr_doread_nxt    = (state_nxt == RD_ISSUE);
    mgr_dowrite_nxt   = (state_nxt == WR_ISSUE);
    mgr_reset_nxt     = (state_nxt == WR_RESET);
    mgr_writemode_nxt = in_write_mode(state_nxt);
    wr_ready_nxt      = (state_nxt == WR_IDLE);
  end

  // State and registered outputs; reset drops any in-flight transaction
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= BOOT;
      last_grant    <= 1'b1;
      cur_client    <= 1'b0;
      wd_cnt        <= '0;
      seen_busy     <= 1'b0;
      c0_ack        <= 1'b0;
      c1_ack        <= 1'b0;
      c0_data       <= '0;
      c1_data       <= '0;
      wr_ready      <= 1'b0;
      w_ack         <= 1'b0;
      err           <= 1'b0;
      mgr_reset     <= 1'b0;
      mgr_writemode <= 1'b0;
      mgr_dowrite   <= 1'b0;
      mgr_wdata     <= '0;
      mgr_doread    <= 1'b0;
      mgr_raddr     <= '0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      cur_client    <= cur_client_nxt;
      wd_cnt        <= wd_cnt_nxt;
      seen_busy     <= seen_busy_nxt;
      c0_ack        <= c0_ack_nxt;
      c1_ack        <= c1_ack_nxt;
      c0_data       <= c0_data_nxt;
      c1_data       <= c1_data_nxt;
      wr_ready      <= wr_ready_nxt;
      w_ack         <= w_ack_nxt;
      err           <= err_nxt;
      mgr_reset     <= mgr_reset_nxt;
      mgr_writemode <= mgr_writemode_nxt;
      mgr_dowrite   <= mgr_dowrite_nxt;
      mgr_wdata     <= mgr_wdata_nxt;
      mgr_doread    <= mgr_doread_nxt;
      mgr_raddr     <= mgr_raddr_nxt;
    end
  end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Directed bench for flash_access_arbiter with a small flash_manager model.
module tb_flash_access_arbiter;
  import flash_access_arbiter_pkg::*;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 11;

  logic clock = 1'b0;
  logic reset;
  logic c0_req, c1_req, c0_ack, c1_ack;
  logic [ADDR_W-1:0] c0_addr, c1_addr, mgr_raddr;
  logic [DATA_W-1:0] c0_data, c1_data, w_data, mgr_wdata;
  logic wsess, wr_ready, w_req, w_ack, err;
  logic mgr_reset, mgr_writemode, mgr_dowrite, mgr_doread;
  logic mgr_busy = 1'b1;
  logic [DATA_W-1:0] mgr_rdata = '0;

  int vec_cnt = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  flash_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clock(clock), .reset(reset),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_ack(c0_ack), .c0_data(c0_data),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_ack(c1_ack), .c1_data(c1_data),
    .wsess(wsess), .wr_ready(wr_ready), .w_req(w_req), .w_data(w_data),
    .w_ack(w_ack), .err(err),
    .mgr_reset(mgr_reset), .mgr_writemode(mgr_writemode),
    .mgr_dowrite(mgr_dowrite), .mgr_wdata(mgr_wdata),
    .mgr_doread(mgr_doread), .mgr_raddr(mgr_raddr),
    .mgr_busy(mgr_busy), .mgr_rdata(mgr_rdata)
  );

  // flash_manager model: busy during boot, read/write/erase busy windows
  logic boot_busy = 1'b1;
  logic ignore_reads = 1'b0;
  int read_lat = 6;
  logic [DATA_W-1:0] rd_value = '0;
  int mdl_cnt = 0;
  logic [DATA_W-1:0] wlog[$];

  always @(posedge clock) begin
    if (boot_busy) begin
      mgr_busy <= 1'b1;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mgr_busy <= 1'b0;
    end else if (mgr_doread && !ignore_reads) begin
      mgr_busy  <= 1'b1;
      mdl_cnt   <= read_lat;
      mgr_rdata <= rd_value;
    end else if (mgr_dowrite) begin
      mgr_busy <= 1'b1;
      mdl_cnt  <= 3;
      wlog.push_back(mgr_wdata);
    end else if (mgr_reset) begin
      mgr_busy <= 1'b1;
      mdl_cnt  <= 5;
    end else begin
      mgr_busy <= 1'b0;
    end
  end

  // Event monitor sampled away from the active edge
  int c0_acks = 0, c1_acks = 0, w_acks = 0;
  int reset_cycles = 0, dowrite_cycles = 0, dowrite_rises = 0, doread_in_wm = 0;
  logic dowrite_prev = 1'b0;
  int ack_order[$];

  always @(negedge clock) begin
    if (c0_ack) begin c0_acks++; ack_order.push_back(0); end
    if (c1_ack) begin c1_acks++; ack_order.push_back(1); end
    if (w_ack) w_acks++;
    if (mgr_reset) reset_cycles++;
    if (mgr_dowrite) dowrite_cycles++;
    if (mgr_dowrite && !dowrite_prev) dowrite_rises++;
    dowrite_prev = mgr_dowrite;
    if (mgr_doread && mgr_writemode) doread_in_wm++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input int which, input logic [ADDR_W-1:0] addr);
    if (which == 0) begin c0_addr = addr; c0_req = 1'b1; end
    else begin c1_addr = addr; c1_req = 1'b1; end
  endtask

  // which: 0 = c0_ack, 1 = c1_ack, 2 = w_ack
  task automatic waitAck(input int which, input int budget, output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      case (which)
        0: seen = c0_ack;
        1: seen = c1_ack;
        default: seen = w_ack;
      endcase
    end
    checkOutput($sformatf("ack%0d_arrived", which), 64'(seen), 64'd1);
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (!wr_ready && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wr_ready_seen", 64'(wr_ready), 64'd1);
  endtask

  function automatic logic [8:0] ctrlBits();
    return {c0_ack, c1_ack, wr_ready, w_ack, err, mgr_reset,
            mgr_writemode, mgr_dowrite, mgr_doread};
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, snap, snap1, ord0, rs0, dw0, dr0, wa0, wl0, wm0;
    logic boot_ok;
    reset = 1'b1;
    c0_req = 0; c1_req = 0; c0_addr = '0; c1_addr = '0;
    wsess = 0; w_req = 0; w_data = '0;
    step(3);

    // Reset state with manager busy
    checkOutput("rst_ctrl", 64'(ctrlBits()), 64'd0);
    checkOutput("rst_state", 64'(dut.state), 64'(BOOT));
    reset = 1'b0;
    boot_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dut.state != BOOT || c0_ack || c1_ack) boot_ok = 1'b0;
    end
    checkOutput("boot_hold", 64'(boot_ok), 64'd1);
    boot_busy = 1'b0;
    step();
    checkOutput("boot_busy_low", 64'(mgr_busy), 64'd0);
    checkOutput("boot_still", 64'(dut.state), 64'(BOOT));
    step();
    checkOutput("boot_rd_idle", 64'(dut.state), 64'(RD_IDLE));

    // Both clients continuously requesting: c0 first, then alternate
    rd_value = 16'h0A0A;
    c0_addr = 23'h000100;
    c1_addr = 23'h000200;
    ord0 = ack_order.size();
    fork
      begin
        int cy0;
        for (int i = 0; i < 3; i++) begin
          c0_req = 1'b1;
          waitAck(0, 80, cy0);
          c0_req = 1'b0;
          step(2);
        end
      end
      begin
        int cy1;
        for (int i = 0; i < 3; i++) begin
          c1_req = 1'b1;
          waitAck(1, 80, cy1);
          c1_req = 1'b0;
          step(2);
        end
      end
    join
    step(3);
    checkOutput("alt_count", 64'(ack_order.size() - ord0), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (ord0 + i < ack_order.size())
        checkOutput($sformatf("alt_grant%0d", i), 64'(ack_order[ord0 + i]), 64'(i % 2));
    end
    checkOutput("alt_c1_data", 64'(c1_data), 64'h0A0A);

    // Single read, 6 busy cycles
    rd_value = 16'hBEEF;
    read_lat = 6;
    snap = c0_acks;
    applyStimulus(0, 23'h000010);
    waitAck(0, 40, cyc);
    checkOutput("rd_data", 64'(c0_data), 64'hBEEF);
    checkOutput("rd_raddr", 64'(mgr_raddr), 64'h10);
    checkOutput("rd_latency", 64'(cyc >= 5), 64'd1);
    c0_req = 1'b0;
    step(3);
    checkOutput("rd_ack_once", 64'(c0_acks - snap), 64'd1);

    // Write session: reset/erase, 3 writes, c1 pending until exit
    rd_value = 16'hC1C1;
    rs0 = reset_cycles; dw0 = dowrite_cycles; dr0 = dowrite_rises;
    wa0 = w_acks; wl0 = wlog.size(); wm0 = doread_in_wm; snap1 = c1_acks;
    wsess = 1'b1;
    waitReady(50);
    checkOutput("wr_reset_once", 64'(reset_cycles - rs0), 64'd1);
    checkOutput("wr_mode_on", 64'(mgr_writemode), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      waitReady(20);
      w_data = DATA_W'(i);
      w_req = 1'b1;
      step();
      w_req = 1'b0;
      waitAck(2, 30, cyc);
      checkOutput($sformatf("wr_wdata%0d", i), 64'(mgr_wdata), 64'(i));
      if (i == 2) applyStimulus(1, 23'h000333);
    end
    step(5);
    checkOutput("wr_c1_pending", 64'(c1_acks - snap1), 64'd0);
    checkOutput("wr_ready_hold", 64'(wr_ready), 64'd1);
    wsess = 1'b0;
    waitAck(1, 40, cyc);
    checkOutput("wr_exit_c1_data", 64'(c1_data), 64'hC1C1);
    checkOutput("wr_exit_c1_raddr", 64'(mgr_raddr), 64'h333);
    checkOutput("wr_mode_off", 64'(mgr_writemode), 64'd0);
    c1_req = 1'b0;
    step(3);
    checkOutput("wr_dowrite_cycles", 64'(dowrite_cycles - dw0), 64'd3);
    checkOutput("wr_dowrite_pulses", 64'(dowrite_rises - dr0), 64'd3);
    checkOutput("wr_ack_count", 64'(w_acks - wa0), 64'd3);
    checkOutput("wr_log_size", 64'(wlog.size() - wl0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (wl0 + k < wlog.size())
        checkOutput($sformatf("wr_log%0d", k), 64'(wlog[wl0 + k]), 64'(k + 1));
    end
    checkOutput("wr_no_read_in_wm", 64'(doread_in_wm - wm0), 64'd0);

    // Watchdog expiry on a read that the manager never starts
    checkOutput("to_err_before", 64'(err), 64'd0);
    ignore_reads = 1'b1;
    applyStimulus(0, 23'h000055);
    waitAck(0, TIMEOUT + 50, cyc);
    checkOutput("to_data", 64'(c0_data), 64'hFFFF);
    checkOutput("to_err", 64'(err), 64'd1);
    checkOutput("to_latency", 64'(cyc >= TIMEOUT && cyc <= TIMEOUT + 4), 64'd1);
    c0_req = 1'b0;
    step(3);
    checkOutput("to_doread_dropped", 64'(mgr_doread), 64'd0);
    ignore_reads = 1'b0;
    rd_value = 16'h1234;
    applyStimulus(0, 23'h000056);
    waitAck(0, 40, cyc);
    checkOutput("to_next_data", 64'(c0_data), 64'h1234);
    checkOutput("to_err_sticky", 64'(err), 64'd1);
    c0_req = 1'b0;
    step(3);

    // Reset while a read waits on the manager
    read_lat = 20;
    rd_value = 16'h7777;
    snap1 = c1_acks;
    applyStimulus(1, 23'h000077);
    cyc = 0;
    while (dut.state != RD_WAIT && cyc < 30) begin step(); cyc++; end
    checkOutput("rst_in_wait", 64'(dut.state), 64'(RD_WAIT));
    step(2);
    reset = 1'b1;
    step();
    checkOutput("rst_mid_ctrl", 64'(ctrlBits()), 64'd0);
    checkOutput("rst_mid_c0_data", 64'(c0_data), 64'd0);
    checkOutput("rst_mid_c1_data", 64'(c1_data), 64'd0);
    checkOutput("rst_mid_wdata", 64'(mgr_wdata), 64'd0);
    checkOutput("rst_mid_raddr", 64'(mgr_raddr), 64'd0);
    checkOutput("rst_mid_state", 64'(dut.state), 64'(BOOT));
    reset = 1'b0;
    c1_req = 1'b0;
    step(30);
    checkOutput("rst_no_ack", 64'(c1_acks - snap1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
